mul_unit: RTL and testbench

MUL_UNIT -- requirements
Module: mul_unit

---
 rtl/mul_unit.sv | 115 +++++++++++
 tb/tb_mul_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// mul_unit -- 8x8 sequential shift-add multiplier feeding reg_file.
//
// An accepted START latches the operands and runs 8 shift-add steps
// (LSB-first over the multiplier), then pulses WRITE for one cycle with
// the destination address and the result. All outputs are registered.
//
// Ports:
//   CLK       in   rising-edge clock
//   RESET     in   asynchronous active-low reset
//   START     in   request a multiply (taken in IDLE, or when leaving DONE)
//   DATA1     in   [7:0] multiplicand
//   DATA2     in   [7:0] multiplier
//   DESTADDR  in   [2:0] destination register index
//   BUSY      out  stall request, high while the multiply runs
//   WRITE     out  one-cycle write-enable to reg_file
//   WRADDR    out  [2:0] write address (held after the write)
//   RESULT    out  [7:0] write data (held after the write)
//   OVF       out  product high byte nonzero; cleared by the next START
//
// Build option: define MUL_SAT_EN to saturate RESULT to 8'hFF on overflow;
// otherwise RESULT is the low byte of the product.
module mul_unit (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic [7:0] DATA1,
   input  logic [7:0] DATA2,
   input  logic [2:0] DESTADDR,
   output logic       BUSY,
   output logic       WRITE,
   output logic [2:0] WRADDR,
   output logic [7:0] RESULT,
   output logic       OVF
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_mcand;
   logic [7:0]  r_mplr;
   logic [2:0]  r_dest;
   logic [15:0] r_acc;
   logic [2:0]  r_cnt;

   logic        w_accept;
   logic        w_last;
   logic [15:0] w_addend;
   logic [15:0] w_sum;
   logic [7:0]  w_res;

   // START is honoured in IDLE and on the edge leaving DONE (back-to-back).
   assign w_accept = START && (r_state == S_IDLE || r_state == S_DONE);
   assign w_last   = (r_state == S_RUN) && (r_cnt == 3'd7);
   assign w_addend = r_mplr[r_cnt] ? ({8'h00, r_mcand} << r_cnt) : 16'h0000;
   assign w_sum    = r_acc + w_addend;

`ifdef MUL_SAT_EN
   assign w_res = (|w_sum[15:8]) ? 8'hFF : w_sum[7:0];
`else
   assign w_res = w_sum[7:0];
`endif

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_RUN;
         S_RUN:   if (w_last)   w_next = S_DONE;
         S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_mcand <= 8'h00;
         r_mplr  <= 8'h00;
         r_dest  <= 3'd0;
         r_acc   <= 16'h0000;
         r_cnt   <= 3'd0;
         BUSY    <= 1'b0;
         WRITE   <= 1'b0;
         WRADDR  <= 3'd0;
         RESULT  <= 8'h00;
         OVF     <= 1'b0;
      end else begin
         // Moore outputs decoded from the state being entered.
         BUSY  <= (w_next == S_RUN);
         WRITE <= (w_next == S_DONE);
         if (w_accept) begin
            r_mcand <= DATA1;
            r_mplr  <= DATA2;
            r_dest  <= DESTADDR;
            r_acc   <= 16'h0000;
            r_cnt   <= 3'd0;
            OVF     <= 1'b0;
         end else if (r_state == S_RUN) begin
            // Always 8 steps; zero operands simply add nothing.
            r_acc <= w_sum;
            r_cnt <= r_cnt + 3'd1;
            if (w_last) begin
               OVF    <= |w_sum[15:8];
               RESULT <= w_res;
               WRADDR <= r_dest;
            end
         end
      end
   end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases, reset abort,
// back-to-back with START held, and randomized operations checked against
// a plain-arithmetic product model.
module tb_mul_unit;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       START;
   logic [7:0] DATA1, DATA2;
   logic [2:0] DESTADDR;
   logic       BUSY, WRITE, OVF;
   logic [2:0] WRADDR;
   logic [7:0] RESULT;

   int n_vec = 0;
   int n_err = 0;

   mul_unit dut (
      .CLK(CLK), .RESET(RESET), .START(START), .DATA1(DATA1), .DATA2(DATA2),
      .DESTADDR(DESTADDR), .BUSY(BUSY), .WRITE(WRITE), .WRADDR(WRADDR),
      .RESULT(RESULT), .OVF(OVF)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Edge then sample on the following falling edge.
   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   function automatic logic [7:0] exp_res(input logic [7:0] a, input logic [7:0] b);
      int p;
      p = int'(a) * int'(b);
`ifdef MUL_SAT_EN
      if (p > 255) return 8'hFF;
`endif
      return p[7:0];
   endfunction

   function automatic logic exp_ovf(input logic [7:0] a, input logic [7:0] b);
      return (int'(a) * int'(b)) > 255;
   endfunction

   // One full operation from IDLE; operands and START are scrambled during RUN.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
      START = 1'b1; DATA1 = a; DATA2 = b; DESTADDR = d;
      tick();                                   // E0
      chk("e0_busy", 16'(BUSY), 16'd1);
      chk("e0_write", 16'(WRITE), 16'd0);
      chk("e0_ovf_clr", 16'(OVF), 16'd0);
      for (int k = 1; k < 8; k++) begin
         START = 1'($urandom); DATA1 = 8'($urandom); DATA2 = 8'($urandom);
         DESTADDR = 3'($urandom);
         tick();                                // E1..E7
         chk("run_busy", 16'(BUSY), 16'd1);
         chk("run_write", 16'(WRITE), 16'd0);
      end
      START = 1'b0;
      tick();                                   // E8
      chk("done_busy", 16'(BUSY), 16'd0);
      chk("done_write", 16'(WRITE), 16'd1);
      chk("done_addr", 16'(WRADDR), 16'(d));
      chk("done_result", 16'(RESULT), 16'(exp_res(a, b)));
      chk("done_ovf", 16'(OVF), 16'(exp_ovf(a, b)));
      tick();                                   // E9 -> IDLE
      chk("idle_write", 16'(WRITE), 16'd0);
      chk("idle_busy", 16'(BUSY), 16'd0);
      chk("idle_result_hold", 16'(RESULT), 16'(exp_res(a, b)));
      chk("idle_addr_hold", 16'(WRADDR), 16'(d));
      chk("idle_ovf_hold", 16'(OVF), 16'(exp_ovf(a, b)));
   endtask

   logic [7:0] a1, b1, a2, b2;
   logic [2:0] d1, d2;

   initial begin
      RESET = 1'b0; START = 1'b0; DATA1 = 8'h00; DATA2 = 8'h00; DESTADDR = 3'd0;
      @(negedge CLK);
      chk("rst_busy", 16'(BUSY), 16'd0);
      chk("rst_write", 16'(WRITE), 16'd0);
      chk("rst_result", 16'(RESULT), 16'h00);
      chk("rst_addr", 16'(WRADDR), 16'd0);
      chk("rst_ovf", 16'(OVF), 16'd0);
      @(negedge CLK);
      RESET = 1'b1;

      run_op(8'h05, 8'h03, 3'd2);
      run_op(8'h10, 8'h10, 3'd5);
      run_op(8'hFF, 8'hFF, 3'd7);
      run_op(8'h00, 8'hA7, 3'd1);
      run_op(8'h80, 8'h01, 3'd3);
      run_op(8'h11, 8'h0F, 3'd4);   // 0xFF: largest non-overflow product
      run_op(8'h02, 8'h80, 3'd6);   // 0x100: smallest overflow product

      // Reset asserted just after E4 of an operation aborts it.
      START = 1'b1; DATA1 = 8'h33; DATA2 = 8'h44; DESTADDR = 3'd6;
      tick();
      START = 1'b0;
      repeat (3) tick();
      @(posedge CLK);
      #2 RESET = 1'b0;
      #1;
      chk("abort_busy", 16'(BUSY), 16'd0);
      chk("abort_write", 16'(WRITE), 16'd0);
      chk("abort_result", 16'(RESULT), 16'h00);
      chk("abort_addr", 16'(WRADDR), 16'd0);
      chk("abort_ovf", 16'(OVF), 16'd0);
      @(negedge CLK);
      RESET = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("abort_no_write", 16'(WRITE), 16'd0);
         chk("abort_idle", 16'(BUSY), 16'd0);
      end
      run_op(8'h05, 8'h03, 3'd2);

      // START held high: operands change at E3, second op accepted at E9.
      a1 = 8'h0C; b1 = 8'h0B; d1 = 3'd3;
      a2 = 8'hC8; b2 = 8'h03; d2 = 3'd5;
      START = 1'b1; DATA1 = a1; DATA2 = b1; DESTADDR = d1;
      for (int e = 0; e <= 17; e++) begin
         if (e == 3) begin DATA1 = a2; DATA2 = b2; DESTADDR = d2; end
         tick();
         if (e == 8) begin
            chk("b2b_w1", 16'(WRITE), 16'd1);
            chk("b2b_r1", 16'(RESULT), 16'(exp_res(a1, b1)));
            chk("b2b_a1", 16'(WRADDR), 16'(d1));
            chk("b2b_o1", 16'(OVF), 16'(exp_ovf(a1, b1)));
         end else if (e == 17) begin
            chk("b2b_w2", 16'(WRITE), 16'd1);
            chk("b2b_r2", 16'(RESULT), 16'(exp_res(a2, b2)));
            chk("b2b_a2", 16'(WRADDR), 16'(d2));
            chk("b2b_o2", 16'(OVF), 16'(exp_ovf(a2, b2)));
         end else begin
            chk("b2b_nowrite", 16'(WRITE), 16'd0);
            chk("b2b_busy", 16'(BUSY), 16'd1);
         end
      end
      START = 1'b0;
      tick();
      chk("b2b_idle", 16'(BUSY), 16'd0);

      for (int n = 0; n < 40; n++)
         run_op(8'($urandom), 8'($urandom), 3'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
